ama_riscv_spec_ctrl: RTL and testbench

Branch speculation controller that drives the branch predictor's pipeline interface and consumes its predictions. It records each conditional-branch prediction made in decode in an in-order queue. It resolves the oldest entry when the branch executes, flags mispredictions, and produces the flush and redirect PC. It also generates the speculation enter/resolve strobes and the actual outcome that the predictor trains on, and keeps branch/mispredict performance counters.

---
 rtl/ama_riscv_spec_ctrl.sv | 88 ++++++++
 tb/tb_ama_riscv_spec_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ama_riscv_spec_ctrl.sv
// ama_riscv_spec_ctrl: in-order branch speculation queue, resolve/flush logic and predictor strobes
module ama_riscv_spec_ctrl #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dec_br_valid,
    input  logic [PC_W-1:0]            dec_pc,
    input  logic                       dec_pred,
    input  logic                       exe_br_valid,
    input  logic [PC_W-1:0]            exe_pc,
    input  logic                       exe_taken,
    input  logic [PC_W-1:0]            exe_tgt,
    output logic                       spec_enter,
    output logic                       spec_resolve,
    output logic                       br_res,
    output logic [PC_W-1:0]            pc_exe_out,
    output logic                       flush,
    output logic [PC_W-1:0]            redirect_pc,
    output logic                       dec_stall,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           cnt_branches,
    output logic [CNT_W-1:0]           cnt_mispred,
    output logic                       err_order
);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {RUN, RECOVER} state_t;

    state_t           state;
    logic [PC_W-1:0]  q_pc   [DEPTH];
    logic             q_pred [DEPTH];
    logic [PTR_W-1:0] head, tail;
    logic             empty;

    // Decode/execute handshakes and the misprediction redirect, all same-cycle
    always_comb begin
        empty        = occupancy == '0;
        spec_resolve = exe_br_valid & !empty;
        br_res       = exe_taken;
        pc_exe_out   = exe_pc;
        flush        = spec_resolve & (q_pred[head] != exe_taken);
        dec_stall    = (occupancy == OCC_W'(DEPTH)) | (state == RECOVER);
        spec_enter   = dec_br_valid & !dec_stall & (state == RUN) & !flush;
        redirect_pc  = !flush ? '0 : exe_taken ? exe_tgt : q_pc[head] + PC_W'(4);
    end

    // Queue storage; contents need no reset since occupancy gates every read
    always_ff @(posedge clk) begin
        if (spec_enter) begin
            q_pc[tail]   <= dec_pc;
            q_pred[tail] <= dec_pred;
        end
    end

    // Pointers, occupancy, recovery state, counters and the sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            occupancy    <= '0;
            state        <= RUN;
            cnt_branches <= '0;
            cnt_mispred  <= '0;
            err_order    <= 1'b0;
        end else begin
            state <= flush ? RECOVER : RUN;
            if (flush) begin
                head      <= '0;
                tail      <= '0;
                occupancy <= '0;
            end else begin
                if (spec_resolve)
                    head <= (head == PTR_W'(DEPTH-1)) ? '0 : head + PTR_W'(1);
                if (spec_enter)
                    tail <= (tail == PTR_W'(DEPTH-1)) ? '0 : tail + PTR_W'(1);
                occupancy <= occupancy + OCC_W'(spec_enter) - OCC_W'(spec_resolve);
            end
            cnt_branches <= cnt_branches + CNT_W'(spec_resolve);
            cnt_mispred  <= cnt_mispred + CNT_W'(flush);
            err_order    <= err_order | (exe_br_valid & empty) |
                            (spec_resolve & (exe_pc != q_pc[head]));
        end
    end
endmodule

// File: tb/tb_ama_riscv_spec_ctrl.sv
// tb_ama_riscv_spec_ctrl: directed self-checking bench for the speculation controller
module tb_ama_riscv_spec_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        dec_br_valid, dec_pred, exe_br_valid, exe_taken;
    logic [31:0] dec_pc, exe_pc, exe_tgt;
    logic        spec_enter, spec_resolve, br_res, flush, dec_stall, err_order;
    logic [31:0] pc_exe_out, redirect_pc, cnt_branches, cnt_mispred;
    logic [1:0]  occupancy;
    int          checks = 0;
    int          errors = 0;
    logic [32:0] mq[$];
    logic [32:0] hd;

    ama_riscv_spec_ctrl #(.DEPTH(2), .PC_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .dec_br_valid(dec_br_valid), .dec_pc(dec_pc), .dec_pred(dec_pred),
        .exe_br_valid(exe_br_valid), .exe_pc(exe_pc), .exe_taken(exe_taken), .exe_tgt(exe_tgt),
        .spec_enter(spec_enter), .spec_resolve(spec_resolve), .br_res(br_res),
        .pc_exe_out(pc_exe_out), .flush(flush), .redirect_pc(redirect_pc),
        .dec_stall(dec_stall), .occupancy(occupancy),
        .cnt_branches(cnt_branches), .cnt_mispred(cnt_mispred), .err_order(err_order)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        dec_br_valid = 0; dec_pc = '0; dec_pred = 0;
        exe_br_valid = 0; exe_pc = '0; exe_taken = 0; exe_tgt = '0;
    endtask

    task automatic enter(input logic [31:0] pc, input logic pred);
        dec_br_valid = 1; dec_pc = pc; dec_pred = pred;
    endtask

    task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        exe_br_valid = 1; exe_pc = pc; exe_taken = taken; exe_tgt = tgt;
    endtask

    initial begin
        idle();
        rst = 1;
        tick(); tick();
        rst = 0;
        #1;
        chk("rst_occ", occupancy, 0);
        chk("rst_cnt_br", cnt_branches, 0);
        chk("rst_cnt_mis", cnt_mispred, 0);
        chk("rst_err", err_order, 0);
        chk("rst_stall", dec_stall, 0);
        chk("rst_flush", flush, 0);
        chk("rst_redirect", redirect_pc, 0);

        // correct prediction
        enter(32'h100, 1); #1;
        chk("c_enter", spec_enter, 1);
        tick(); idle();
        chk("c_occ1", occupancy, 1);
        resolve(32'h100, 1, 32'h180); #1;
        chk("c_resolve", spec_resolve, 1);
        chk("c_br_res", br_res, 1);
        chk("c_pc_exe", pc_exe_out, 32'h100);
        chk("c_flush", flush, 0);
        chk("c_redirect", redirect_pc, 0);
        tick(); idle();
        chk("c_occ0", occupancy, 0);
        chk("c_cnt_br", cnt_branches, 1);
        chk("c_cnt_mis", cnt_mispred, 0);

        // predicted taken, actually not taken
        enter(32'h200, 1); tick(); idle();
        resolve(32'h200, 0, 32'h280); #1;
        chk("t_flush", flush, 1);
        chk("t_redirect", redirect_pc, 32'h204);
        chk("t_br_res", br_res, 0);
        tick(); idle();
        enter(32'h210, 1); #1;
        chk("t_occ", occupancy, 0);
        chk("t_stall_recover", dec_stall, 1);
        chk("t_enter_recover", spec_enter, 0);
        chk("t_cnt_br", cnt_branches, 2);
        chk("t_cnt_mis", cnt_mispred, 1);
        tick(); idle(); #1;
        chk("t_stall_run", dec_stall, 0);
        chk("t_occ_after", occupancy, 0);

        // predicted not taken, taken, younger branch queued
        enter(32'h300, 0); tick();
        enter(32'h310, 1); tick(); idle();
        chk("n_occ2", occupancy, 2);
        resolve(32'h300, 1, 32'h400); enter(32'h320, 1); #1;
        chk("n_flush", flush, 1);
        chk("n_redirect", redirect_pc, 32'h400);
        chk("n_enter", spec_enter, 0);
        tick(); idle();
        chk("n_occ0", occupancy, 0);
        chk("n_cnt_br", cnt_branches, 3);
        chk("n_cnt_mis", cnt_mispred, 2);
        tick();

        // flush drops a same-cycle enter that would otherwise be accepted
        enter(32'h500, 1); tick(); idle();
        resolve(32'h500, 0, 32'h5f0); enter(32'h510, 0); #1;
        chk("d_stall", dec_stall, 0);
        chk("d_flush", flush, 1);
        chk("d_enter", spec_enter, 0);
        chk("d_redirect", redirect_pc, 32'h504);
        tick(); idle();
        chk("d_occ", occupancy, 0);
        chk("d_cnt_mis", cnt_mispred, 3);
        tick();

        // full queue, stall at full even with a pop, then wrap-around
        enter(32'h600, 1); tick();
        enter(32'h604, 0); tick();
        enter(32'h608, 1); #1;
        chk("f_occ2", occupancy, 2);
        chk("f_stall", dec_stall, 1);
        chk("f_enter", spec_enter, 0);
        tick(); idle();
        chk("f_occ_hold", occupancy, 2);
        resolve(32'h600, 1, 32'h0); enter(32'h608, 1); #1;
        chk("f_enter_pop", spec_enter, 0);
        chk("f_flush_pop", flush, 0);
        tick(); idle();
        chk("f_occ1", occupancy, 1);
        mq.push_back({1'b0, 32'h604});
        for (int i = 0; i < 6; i++) begin
            hd = mq[0];
            resolve(hd[31:0], hd[32], 32'h0);
            enter(32'h700 + 32'(4 * i), ~i[0]);
            #1;
            chk("w_enter", spec_enter, 1);
            chk("w_resolve", spec_resolve, 1);
            chk("w_flush", flush, 0);
            tick(); idle();
            void'(mq.pop_front());
            mq.push_back({~i[0], 32'h700 + 32'(4 * i)});
            chk("w_occ", occupancy, 1);
        end
        hd = mq[0];
        chk("w_model_head", hd, {1'b0, 32'h714});
        resolve(hd[31:0], hd[32], 32'h0); #1;
        chk("w_drain_flush", flush, 0);
        tick(); idle();
        chk("w_occ0", occupancy, 0);
        chk("w_err", err_order, 0);
        chk("w_cnt_br", cnt_branches, 12);
        chk("w_cnt_mis", cnt_mispred, 3);

        // resolve with empty queue
        resolve(32'h900, 1, 32'h0); #1;
        chk("e_resolve", spec_resolve, 0);
        chk("e_flush", flush, 0);
        tick(); idle();
        chk("e_err", err_order, 1);
        chk("e_cnt_br", cnt_branches, 12);
        tick();
        chk("e_err_sticky", err_order, 1);
        rst = 1; tick(); rst = 0;
        chk("e_err_clr", err_order, 0);

        // resolve pc mismatch still pops
        enter(32'ha00, 1); tick(); idle();
        resolve(32'ha08, 1, 32'h0); #1;
        chk("m_resolve", spec_resolve, 1);
        chk("m_flush", flush, 0);
        tick(); idle();
        chk("m_err", err_order, 1);
        chk("m_occ", occupancy, 0);
        chk("m_cnt_br", cnt_branches, 1);

        // reset while full with a flush pending
        enter(32'hb00, 1); tick();
        enter(32'hb04, 1); tick(); idle();
        chk("r_occ2", occupancy, 2);
        resolve(32'hb00, 0, 32'h0); rst = 1; tick(); rst = 0; idle(); #1;
        chk("r_occ", occupancy, 0);
        chk("r_cnt_br", cnt_branches, 0);
        chk("r_cnt_mis", cnt_mispred, 0);
        chk("r_err", err_order, 0);
        chk("r_stall", dec_stall, 0);
        enter(32'hc00, 0); #1;
        chk("r_enter", spec_enter, 1);
        tick(); idle();
        resolve(32'hc00, 0, 32'h0); #1;
        chk("r_flush", flush, 0);
        tick(); idle();
        chk("r_post_occ", occupancy, 0);
        chk("r_post_cnt", cnt_branches, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
